approx_mac_accumulator: RTL and testbench
=========================================

// Module: approx_mac_accumulator
// PURPOSE
// - Downstream consumer of the 8x8 Wallace-tree multiplier tops (exact or approximate): sums a frame of 16-bit products into one wide result.
// - Operands drive the multiplier and this block in parallel; op_valid/op_last travel through an internal MULT_LAT delay line so they align with prod_in.
// - The finished sum is held in a result register with a valid/ready output handshake. Used to measure how approximate-product error accumulates across a frame.
// PARAMETERS
// - ACC_W     24  accumulator/result width (>=16)
// - MULT_LAT  2   edges from operand sample at multiplier A_in/B_in to product sample at prod_in
// - SATURATE  0   1: clamp at 2^ACC_W-1; 0: wrap modulo 2^ACC_W
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      synchronous, active-high reset
// - op_valid   in   1      operands on multiplier A_in/B_in are valid this cycle
// - op_last    in   1      qualifies op_valid: final term of the frame
// - prod_in    in   16     multiplier S_out
// - res_data   out  ACC_W  frame sum
// - res_ovf    out  1      frame overflowed ACC_W (wrapped or clamped)
// - res_valid  out  1      res_data/res_ovf valid
// - res_ready  in   1      consumer accepts result
// - overrun    out  1      sticky: a frame completed while the previous result was still unaccepted
// - busy       out  1      frame in progress or terms in flight
// BEHAVIOUR
// - Reset: all outputs 0; acc, term flags, and delay line cleared. Reset mid-frame discards the partial sum and all in-flight terms.
// - The delay line shifts {op_valid, op_last} every edge; there is no input stall because the multiplier pipeline cannot stall. Tap MULT_LAT gives p_valid/p_last.
// - FSM states: IDLE (no partial sum) and ACCUM (partial sum held).
//   - On p_valid in IDLE: acc <= prod_in. If p_last, stay in IDLE; otherwise go to ACCUM.
//   - On p_valid in ACCUM: acc <= acc + prod_in, using an ACC_W+1-bit add; the carry sets frame_ovf.
//   - On p_valid & p_last: go to IDLE.
// - Saturation: if SATURATE=1 and the sum >= 2^ACC_W, acc <= all-ones, and subsequent adds in the frame stay clamped.
// - Completion on p_valid & p_last:
//   - Result slot free (!res_valid, or res_valid & res_ready this edge): load res_data = final sum and res_ovf = frame_ovf. res_valid is high from that edge onward, i.e. MULT_LAT edges after the edge that sampled the last operand.
//   - Slot full and not accepted: drop the new result, set overrun (cleared only by rst), and keep the held result unchanged.
// - Single-term frame (op_valid & op_last together): result = that product.
// - Back-to-back frames: a new first term on the edge after a last term is legal. No bubble is required, and the FSM goes IDLE -> ACCUM directly.
// - Handshake: res_valid is held, and res_data is stable, until res_valid & res_ready. Ready may be high early. res_valid is never combinationally dependent on res_ready.
// - op_last without op_valid is ignored.
// - busy = (state==ACCUM) | any delay-line valid bit.
// STRUCTURE
// - Shared package acc_pkg: MULT_LAT_DEFAULT=2, PROD_W=16, and the state enum {IDLE, ACCUM}.
// - Sub-module: mult_lat_delay (parameterised DEPTH, WIDTH=2 shift register with synchronous reset) for valid/last alignment.
// - The adder/saturation logic stays inline.
// TESTING (ACC_W=24, MULT_LAT=2, SATURATE=0 unless noted; each stimulus passes through a real multiplier top)
// - Frame 3x5, 7x9, 255x255 (last) -> res_data=65103, res_ovf=0; res_valid rises 2 edges after the last operand edge.
// - SATURATE=1, ACC_W=16: 255x255, 255x255 (last) -> res_data=65535, res_ovf=1. With SATURATE=0 -> res_data=64514, res_ovf=1.
// - Single-term frame 12x12 with res_ready=1, then a second frame 2x2 starting the next cycle -> results 144 then 4, with no gap and no overrun.
// - res_ready=0 and two frames complete (sums 10, then 20) -> res_data stays 10, overrun=1. Raising ready afterwards gives one handshake, then res_valid=0.
// - rst asserted mid-frame after 2 of 4 terms, frame restarted with 1x1 (last) -> res_data=1; no term from before the reset contributes.
// - Randomised frames of 1..64 terms with random res_ready, against a scoreboard sum of the multiplier outputs -> all results match, overrun only when the model predicts it.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and constants for the product accumulator.
// Imported by the delay line and the accumulator top.
package acc_pkg;

   localparam int MULT_LAT_DEFAULT = 2;
   localparam int PROD_W = 16;

   typedef enum logic {
      IDLE,
      ACCUM
   } acc_state_t;

endpackage

// File: rtl/mult_lat_delay.sv
// Fixed-depth shift register aligning operand flags with products.
// The MSB of each word is treated as its valid flag for occupancy.
module mult_lat_delay #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             occ
);

   logic [DEPTH-1:0][WIDTH-1:0] sr;

   // Shift every edge; the multiplier pipeline never stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   // Any stage still carrying a valid flag.
   always_comb begin
      occ = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         occ = occ | sr[i][WIDTH-1];
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/approx_mac_accumulator.sv
// Sums a frame of multiplier products into one wide result
// held behind a valid/ready handshake, with overflow tracking.
module approx_mac_accumulator
   import acc_pkg::*;
#(
   parameter int ACC_W    = 24,
   parameter int MULT_LAT = MULT_LAT_DEFAULT,
   parameter bit SATURATE = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid,
   input  logic              op_last,
   input  logic [PROD_W-1:0] prod_in,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_ovf,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              overrun,
   output logic              busy
);

   acc_state_t       state;
   logic [ACC_W-1:0] acc;
   logic             frame_ovf;

   logic [1:0]       p_flags;
   logic             p_valid;
   logic             p_last;
   logic             in_flight;

   logic [ACC_W:0]   base;
   logic [ACC_W:0]   sum_ext;
   logic             carry;
   logic [ACC_W-1:0] nxt_acc;
   logic             nxt_ovf;
   logic             slot_free;

   mult_lat_delay #(
      .DEPTH (MULT_LAT),
      .WIDTH (2)
   ) u_dly (
      .clk (clk),
      .rst (rst),
      .d   ({op_valid, op_valid & op_last}),
      .q   (p_flags),
      .occ (in_flight)
   );

   assign p_valid = p_flags[1];
   assign p_last  = p_flags[0];

   // Next sum: a first term starts from zero, later terms add to acc.
   always_comb begin
      base    = (state == ACCUM) ? {1'b0, acc} : '0;
      sum_ext = base + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
      carry   = sum_ext[ACC_W];
      if (SATURATE && carry) begin
         nxt_acc = '1;
      end else begin
         nxt_acc = sum_ext[ACC_W-1:0];
      end
      nxt_ovf = carry | ((state == ACCUM) & frame_ovf);
   end

   assign slot_free = !res_valid || res_ready;

   // Frame FSM, result slot and sticky overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         frame_ovf <= 1'b0;
         res_data  <= '0;
         res_ovf   <= 1'b0;
         res_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
         if (p_valid) begin
            acc       <= nxt_acc;
            frame_ovf <= nxt_ovf;
            if (p_last) begin
               state <= IDLE;
               if (slot_free) begin
                  res_data  <= nxt_acc;
                  res_ovf   <= nxt_ovf;
                  res_valid <= 1'b1;
               end else begin
                  overrun <= 1'b1;
               end
            end else begin
               state <= ACCUM;
            end
         end
      end
   end

   assign busy = (state == ACCUM) | in_flight;

endmodule

// File: tb/tb_approx_mac_accumulator.sv
// Randomised and directed bench for approx_mac_accumulator.
// Products come from a two-stage multiplier stand-in.
module tb_approx_mac_accumulator;

   localparam int ACC_W = 24;
   localparam int MLAT  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        op_valid = 1'b0;
   logic        op_last = 1'b0;
   logic        res_ready = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic [15:0] m1 = '0;
   logic [15:0] m2 = '0;

   logic [23:0] res_data;
   logic        res_ovf, res_valid, overrun, busy;
   logic [15:0] s_data, w_data;
   logic        s_ovf, s_valid, s_ovr, s_busy;
   logic        w_ovf, w_valid, w_ovr, w_busy;

   always #5 clk = ~clk;

   // Two-stage multiplier: operands sampled at edge n, product sampled by DUT at n+2.
   always @(posedge clk) begin
      m1 <= 16'(a) * 16'(b);
      m2 <= m1;
   end

   approx_mac_accumulator #(.ACC_W(24), .MULT_LAT(2), .SATURATE(1'b0)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_last(op_last),
      .prod_in(m2), .res_data(res_data), .res_ovf(res_ovf),
      .res_valid(res_valid), .res_ready(res_ready),
      .overrun(overrun), .busy(busy));

   approx_mac_accumulator #(.ACC_W(16), .MULT_LAT(2), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_last(op_last),
      .prod_in(m2), .res_data(s_data), .res_ovf(s_ovf),
      .res_valid(s_valid), .res_ready(res_ready),
      .overrun(s_ovr), .busy(s_busy));

   approx_mac_accumulator #(.ACC_W(16), .MULT_LAT(2), .SATURATE(1'b0)) dut_w (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_last(op_last),
      .prod_in(m2), .res_data(w_data), .res_ovf(w_ovf),
      .res_valid(w_valid), .res_ready(res_ready),
      .overrun(w_ovr), .busy(w_busy));

   typedef struct {
      int     at;
      longint sum;
   } pend_t;

   pend_t  pend[$];
   int     edge_n = 0;
   longint fsum = 0;
   bit     m_valid = 0;
   bit     m_ovf = 0;
   bit     m_ovr = 0;
   longint m_data = 0;
   int     checks = 0;
   int     failures = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock edge: update the frame/result-slot model, then compare.
   task automatic tick();
      pend_t  p;
      longint lim;
      lim = longint'(1) << ACC_W;
      @(posedge clk);
      edge_n++;
      if (rst) begin
         pend.delete();
         fsum    = 0;
         m_valid = 0;
         m_ovf   = 0;
         m_ovr   = 0;
         m_data  = 0;
      end else begin
         if (m_valid && res_ready) m_valid = 0;
         if (pend.size() > 0 && pend[0].at == edge_n) begin
            p = pend.pop_front();
            if (!m_valid) begin
               m_valid = 1;
               m_data  = p.sum % lim;
               m_ovf   = (p.sum >= lim);
            end else begin
               m_ovr = 1;
            end
         end
         if (op_valid) begin
            fsum += longint'(a) * longint'(b);
            if (op_last) begin
               pend.push_back('{edge_n + MLAT, fsum});
               fsum = 0;
            end
         end
      end
      #1;
      chk("res_valid", longint'(res_valid), longint'(m_valid));
      chk("overrun", longint'(overrun), longint'(m_ovr));
      if (m_valid) begin
         chk("res_data", longint'(res_data), m_data);
         chk("res_ovf", longint'(res_ovf), longint'(m_ovf));
      end
   endtask

   task automatic op(input int x, input int y, input bit v, input bit l);
      a        = 8'(x);
      b        = 8'(y);
      op_valid = v;
      op_last  = l;
      tick();
   endtask

   task automatic idle();
      op_valid = 1'b0;
      op_last  = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      op_valid = 1'b0;
      op_last  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int n;

      do_reset();
      chk("rst_valid", longint'(res_valid), 0);
      chk("rst_data", longint'(res_data), 0);
      chk("rst_ovf", longint'(res_ovf), 0);
      chk("rst_overrun", longint'(overrun), 0);
      chk("rst_busy", longint'(busy), 0);

      // Three-term frame, result timing.
      res_ready = 1'b0;
      op(3, 5, 1, 0);
      chk("busy_mid", longint'(busy), 1);
      op(7, 9, 1, 0);
      op(255, 255, 1, 1);
      idle();
      chk("valid_lat1", longint'(res_valid), 0);
      idle();
      chk("valid_lat2", longint'(res_valid), 1);
      chk("frame1_data", longint'(res_data), 65103);
      chk("frame1_ovf", longint'(res_ovf), 0);
      repeat (3) idle();
      chk("busy_done", longint'(busy), 0);
      res_ready = 1'b1;
      idle();
      res_ready = 1'b0;
      chk("frame1_taken", longint'(res_valid), 0);

      // Narrow accumulators: saturate vs wrap.
      do_reset();
      op(255, 255, 1, 0);
      op(255, 255, 1, 1);
      idle();
      idle();
      chk("sat_valid", longint'(s_valid), 1);
      chk("sat_data", longint'(s_data), 65535);
      chk("sat_ovf", longint'(s_ovf), 1);
      chk("wrap_data", longint'(w_data), 64514);
      chk("wrap_ovf", longint'(w_ovf), 1);
      chk("wide_data", longint'(res_data), 130050);

      // Single-term frame then back-to-back frame, ready held high.
      do_reset();
      res_ready = 1'b1;
      op(12, 12, 1, 1);
      op(2, 2, 1, 1);
      idle();
      chk("b2b_first", longint'(res_data), 144);
      idle();
      chk("b2b_second", longint'(res_data), 4);
      chk("b2b_valid", longint'(res_valid), 1);
      chk("b2b_overrun", longint'(overrun), 0);
      idle();

      // Two completions while the slot is full.
      do_reset();
      res_ready = 1'b0;
      op(1, 10, 1, 1);
      repeat (3) idle();
      op(4, 5, 1, 1);
      repeat (3) idle();
      chk("held_data", longint'(res_data), 10);
      chk("held_overrun", longint'(overrun), 1);
      res_ready = 1'b1;
      idle();
      res_ready = 1'b0;
      idle();
      chk("drained_valid", longint'(res_valid), 0);
      chk("overrun_sticky", longint'(overrun), 1);

      // Reset mid-frame discards partial sum and in-flight terms.
      do_reset();
      res_ready = 1'b1;
      op(5, 5, 1, 0);
      op(6, 6, 1, 0);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      op(1, 1, 1, 1);
      idle();
      idle();
      chk("restart_data", longint'(res_data), 1);
      chk("restart_valid", longint'(res_valid), 1);

      // Randomised frames with random gaps and ready.
      do_reset();
      for (int f = 0; f < 30; f++) begin
         n = int'($urandom_range(1, 64));
         for (int t = 0; t < n; t++) begin
            while ($urandom_range(0, 3) == 0) begin
               res_ready = 1'($urandom_range(0, 1));
               op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  1'b0, 1'($urandom_range(0, 1)));
            end
            res_ready = 1'($urandom_range(0, 1));
            op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               1'b1, (t == n - 1));
         end
      end
      res_ready = 1'b1;
      repeat (10) idle();
      chk("final_valid", longint'(res_valid), 0);
      chk("final_busy", longint'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
